// File: rtl/xras_policy_exec_mc_if.sv
// Event/result bundle between the XRAS event collectors, the multi-channel
// policy executor and the action/billing sinks.
interface xras_policy_exec_mc_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]        ev_valid;
  logic [NUM_CH-1:0]        ev_ready;
  logic [NUM_CH*8-1:0]      ev_type;
  logic [NUM_CH*DATA_W-1:0] ev_severity;
  logic [NUM_CH*DATA_W-1:0] ev_boundary;
  logic                     out_valid;
  logic                     out_ready;
  logic [CW-1:0]            out_ch;
  logic [DATA_W-1:0]        out_penalty;
  logic [DATA_W-1:0]        out_credit;
  logic [7:0]               out_action;
  logic [DATA_W-1:0]        out_actor;
  logic                     out_escalated;

  // Collector/sink side: produces events, consumes results
  modport master (
    output ev_valid, ev_type, ev_severity, ev_boundary, out_ready,
    input  ev_ready, out_valid, out_ch, out_penalty, out_credit,
           out_action, out_actor, out_escalated
  );

  // Executor side
  modport slave (
    input  ev_valid, ev_type, ev_severity, ev_boundary, out_ready,
    output ev_ready, out_valid, out_ch, out_penalty, out_credit,
           out_action, out_actor, out_escalated
  );
endinterface

// File: rtl/xras_policy_exec_mc.sv
// Multi-channel XRAS policy executor: round-robin event arbitration, a
// two-stage penalty/credit/action pipeline with per-channel fault escalation
// and a per-channel saturating penalty ledger.
module xras_policy_exec_mc #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 32,
  parameter int BASE_PENALTY = 1000,
  parameter int CREDIT_AMT   = 100,
  parameter int ESC_THRESH   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  xras_policy_exec_mc_if.slave      bus,
  input  logic [$clog2(NUM_CH)-1:0] ledger_sel,
  input  logic                      ledger_clr,
  output logic [DATA_W-1:0]         ledger_val
);

  localparam int CW = $clog2(NUM_CH);

  // Penalty = (BASE_PENALTY*severity) >> shift(type), saturated to DATA_W
  function automatic logic [DATA_W-1:0] calc_penalty(input logic [7:0] typ,
                                                     input logic [DATA_W-1:0] sev);
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] shd;
    prod = (2*DATA_W)'(BASE_PENALTY) * {{DATA_W{1'b0}}, sev};
    case (typ)
      8'd1:    shd = prod >> 6;
      8'd2:    shd = prod >> 5;
      8'd3:    shd = prod >> 3;
      8'd4:    shd = prod >> 2;
      default: shd = '0;
    endcase
    if (|shd[2*DATA_W-1:DATA_W]) return '1;
    return shd[DATA_W-1:0];
  endfunction

  // Unsigned add clamped at all-ones
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DATA_W]) return '1;
    return s[DATA_W-1:0];
  endfunction

  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     gidx;
  logic [CW-1:0]     ptr_nxt;
  logic              found;
  logic              adv;
  logic              ev_xfer;
  logic              out_xfer;

  logic              vld_p1;
  logic [CW-1:0]     ch_p1;
  logic [7:0]        type_p1;
  logic [DATA_W-1:0] sev_p1;
  logic [DATA_W-1:0] bnd_p1;

  logic              vld_p2;
  logic [CW-1:0]     ch_p2;
  logic [DATA_W-1:0] pen_p2;
  logic [DATA_W-1:0] cred_p2;
  logic [7:0]        act_p2;
  logic [DATA_W-1:0] actor_p2;
  logic              esc_p2;

  logic [DATA_W-1:0] pen_c;
  logic [DATA_W-1:0] cred_c;
  logic [7:0]        act_c;
  logic              esc_c;
  logic              cnt_wr;
  logic [3:0]        cnt_cur;
  logic [3:0]        cnt_nxt;

  logic [3:0]        esc_cnt [NUM_CH];
  logic [DATA_W-1:0] ledger  [NUM_CH];

  // A full output register that is not being drained freezes the whole pipe
  assign adv      = !vld_p2 || bus.out_ready;
  assign ev_xfer  = found && adv;
  assign out_xfer = vld_p2 && bus.out_ready;

  // Round-robin search for the first valid channel at/after the pointer
  always_comb begin
    found   = 1'b0;
    gidx    = '0;
    ptr_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && bus.ev_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        gidx  = CW'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
    ptr_nxt = (gidx == CW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
    bus.ev_ready = '0;
    if (ev_xfer) bus.ev_ready[gidx] = 1'b1;
  end

  // ---- Stage 1: capture the granted event ----
  // S1 payload registers; only the valid bit needs reset
  always_ff @(posedge clk) begin
    if (ev_xfer) begin
      ch_p1   <= gidx;
      type_p1 <= bus.ev_type[int'(gidx)*8 +: 8];
      sev_p1  <= bus.ev_severity[int'(gidx)*DATA_W +: DATA_W];
      bnd_p1  <= bus.ev_boundary[int'(gidx)*DATA_W +: DATA_W];
    end
  end

  // ---- Stage 2: penalty, credit, action and escalation ----
  // Result computation from the S1 event and its channel's escalation count
  always_comb begin
    pen_c   = '0;
    cred_c  = '0;
    act_c   = 8'd0;
    esc_c   = 1'b0;
    cnt_wr  = 1'b0;
    cnt_cur = esc_cnt[ch_p1];
    cnt_nxt = cnt_cur;
    case (type_p1)
      8'd0: begin
        cred_c  = DATA_W'(CREDIT_AMT);
        cnt_wr  = 1'b1;
        cnt_nxt = 4'd0;
      end
      8'd1: begin
        pen_c = calc_penalty(type_p1, sev_p1);
        act_c = 8'd1;
      end
      8'd2, 8'd3, 8'd4: begin
        pen_c   = calc_penalty(type_p1, sev_p1);
        act_c   = type_p1;
        cnt_wr  = 1'b1;
        cnt_nxt = (cnt_cur == 4'd15) ? 4'd15 : cnt_cur + 4'd1;
        if (int'(cnt_cur) >= ESC_THRESH - 1) begin
          act_c = (type_p1 == 8'd4) ? 8'd4 : type_p1 + 8'd1;
          esc_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pipeline control, result registers, RR pointer and escalation counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      ch_p2    <= '0;
      pen_p2   <= '0;
      cred_p2  <= '0;
      act_p2   <= 8'd0;
      actor_p2 <= '0;
      esc_p2   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) esc_cnt[i] <= 4'd0;
    end else if (adv) begin
      vld_p1 <= ev_xfer;
      vld_p2 <= vld_p1;
      if (ev_xfer) rr_ptr <= ptr_nxt;
      if (vld_p1) begin
        ch_p2    <= ch_p1;
        pen_p2   <= pen_c;
        cred_p2  <= cred_c;
        act_p2   <= act_c;
        actor_p2 <= bnd_p1;
        esc_p2   <= esc_c;
        if (cnt_wr) esc_cnt[ch_p1] <= cnt_nxt;
      end
    end
  end

  // Penalty ledger: accumulate on result transfer, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ledger[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ledger_clr && ledger_sel == CW'(i))
          ledger[i] <= '0;
        else if (out_xfer && ch_p2 == CW'(i))
          ledger[i] <= sat_add(ledger[i], pen_p2);
      end
    end
  end

  assign ledger_val        = ledger[ledger_sel];
  assign bus.out_valid     = vld_p2;
  assign bus.out_ch        = ch_p2;
  assign bus.out_penalty   = pen_p2;
  assign bus.out_credit    = cred_p2;
  assign bus.out_action    = act_p2;
  assign bus.out_actor     = actor_p2;
  assign bus.out_escalated = esc_p2;

endmodule

// File: tb/tb_xras_policy_exec_mc.sv
// Directed bench for the multi-channel XRAS policy executor.
module tb_xras_policy_exec_mc;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [1:0]        ledger_sel;
  logic              ledger_clr;
  logic [DATA_W-1:0] ledger_val;

  int total = 0;
  int bad   = 0;

  xras_policy_exec_mc_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  xras_policy_exec_mc #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BASE_PENALTY(1000),
    .CREDIT_AMT(100), .ESC_THRESH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ledger_sel(ledger_sel), .ledger_clr(ledger_clr), .ledger_val(ledger_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input int ch, input logic [7:0] typ,
                        input logic [31:0] sev, input logic [31:0] bnd);
    bus.ev_type[ch*8 +: 8]             = typ;
    bus.ev_severity[ch*DATA_W +: DATA_W] = sev;
    bus.ev_boundary[ch*DATA_W +: DATA_W] = bnd;
  endtask

  logic [7:0]  d_type [5] = '{8'd2, 8'd2, 8'd2, 8'd0, 8'd2};
  logic [7:0]  d_act  [5] = '{8'd2, 8'd2, 8'd3, 8'd0, 8'd2};
  logic        d_esc  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] d_pen  [5] = '{32'd2000, 32'd2000, 32'd2000, 32'd0, 32'd2000};
  logic [31:0] d_cred [5] = '{32'd0, 32'd0, 32'd0, 32'd100, 32'd0};

  initial begin
    int j;
    int r;
    logic [31:0] held;
    rst_n           = 1'b0;
    ledger_sel      = 2'd0;
    ledger_clr      = 1'b0;
    bus.ev_valid    = '0;
    bus.ev_type     = '0;
    bus.ev_severity = '0;
    bus.ev_boundary = '0;
    bus.out_ready   = 1'b1;

    // reset state
    repeat (2) tick();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_penalty", bus.out_penalty, 32'd0);
    chk("rst_action", bus.out_action, 8'd0);
    chk("rst_ledger", ledger_val, 32'd0);
    chk("rst_ev_ready", bus.ev_ready, 4'b0000);
    rst_n = 1'b1;
    tick();

    // round robin, all channels valid, type 0
    for (int c = 0; c < NUM_CH; c++) set_ev(c, 8'd0, 32'd5, 32'h100 + c);
    for (int k = 0; k < 8; k++) begin
      bus.ev_valid = (k < 6) ? 4'hF : 4'h0;
      #1;
      if (k < 6) chk("rr_grant", bus.ev_ready, 4'b0001 << (k % 4));
      if (k >= 2) begin
        chk("rr_valid", bus.out_valid, 1'b1);
        chk("rr_ch", bus.out_ch, (k - 2) % 4);
        chk("rr_actor", bus.out_actor, 32'h100 + (k - 2) % 4);
        chk("rr_credit", bus.out_credit, 32'd100);
        chk("rr_penalty", bus.out_penalty, 32'd0);
      end
      tick();
    end
    chk("rr_drained", bus.out_valid, 1'b0);

    // ch2 type3 severity 10, alone
    set_ev(2, 8'd3, 32'd10, 32'hAB);
    bus.ev_valid = 4'b0100;
    #1;
    chk("t3_grant", bus.ev_ready, 4'b0100);
    tick();
    bus.ev_valid = 4'b0000;
    #1;
    chk("t3_lat1", bus.out_valid, 1'b0);
    tick();
    chk("t3_valid", bus.out_valid, 1'b1);
    chk("t3_penalty", bus.out_penalty, 32'd1250);
    chk("t3_action", bus.out_action, 8'd3);
    chk("t3_ch", bus.out_ch, 2'd2);
    chk("t3_credit", bus.out_credit, 32'd0);
    chk("t3_actor", bus.out_actor, 32'hAB);
    chk("t3_esc", bus.out_escalated, 1'b0);
    ledger_sel = 2'd2;
    tick();
    chk("t3_done", bus.out_valid, 1'b0);
    chk("t3_ledger", ledger_val, 32'd1250);

    // escalation on ch1: type2 x3, type0, type2
    for (int k = 0; k < 7; k++) begin
      bus.ev_valid = (k < 5) ? 4'b0010 : 4'b0000;
      if (k < 5) set_ev(1, d_type[k], 32'd64, 32'h11);
      #1;
      if (k < 5) chk("esc_grant", bus.ev_ready, 4'b0010);
      if (k >= 2) begin
        chk("esc_valid", bus.out_valid, 1'b1);
        chk("esc_action", bus.out_action, d_act[k-2]);
        chk("esc_flag", bus.out_escalated, d_esc[k-2]);
        chk("esc_penalty", bus.out_penalty, d_pen[k-2]);
        chk("esc_credit", bus.out_credit, d_cred[k-2]);
      end
      tick();
    end
    ledger_sel = 2'd1;
    #1;
    chk("esc_ledger", ledger_val, 32'd8000);

    // type4 with max severity saturates penalty and ledger
    set_ev(3, 8'd4, 32'hFFFF_FFFF, 32'h33);
    for (int k = 0; k < 4; k++) begin
      bus.ev_valid = (k < 2) ? 4'b1000 : 4'b0000;
      #1;
      if (k >= 2) begin
        chk("sat_penalty", bus.out_penalty, 32'hFFFF_FFFF);
        chk("sat_action", bus.out_action, 8'd4);
        chk("sat_ch", bus.out_ch, 2'd3);
      end
      tick();
    end
    ledger_sel = 2'd3;
    #1;
    chk("sat_ledger", ledger_val, 32'hFFFF_FFFF);
    tick();

    // output stall with ch0 streaming type1 events
    j = 0;
    r = 0;
    held = '0;
    for (int s = 0; s < 30; s++) begin
      bus.out_ready = !(s >= 3 && s < 8);
      bus.ev_valid  = (j < 6) ? 4'b0001 : 4'b0000;
      set_ev(0, 8'd1, 32'(64 * (j + 1)), 32'h44);
      #1;
      if (s == 3) held = bus.out_penalty;
      if (s >= 3 && s < 8) chk("stall_ev_ready", bus.ev_ready, 4'b0000);
      if (s >= 4 && s < 8) begin
        chk("stall_valid", bus.out_valid, 1'b1);
        chk("stall_hold", bus.out_penalty, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("stall_order", bus.out_penalty, 32'(1000 * (r + 1)));
        r++;
      end
      if (bus.ev_ready[0]) j++;
      tick();
    end
    chk("stall_count", r, 6);
    bus.out_ready = 1'b1;

    // ledger clear coincident with a ch0 result transfer
    set_ev(0, 8'd1, 32'd64, 32'h55);
    bus.ev_valid = 4'b0001;
    #1;
    tick();
    bus.ev_valid = 4'b0000;
    tick();
    chk("clr_valid", bus.out_valid, 1'b1);
    chk("clr_penalty", bus.out_penalty, 32'd1000);
    ledger_sel = 2'd0;
    #1;
    chk("clr_ledger_before", ledger_val, 32'd21000);
    ledger_clr = 1'b1;
    tick();
    ledger_clr = 1'b0;
    #1;
    chk("clr_ledger_after", ledger_val, 32'd0);
    chk("clr_drained", bus.out_valid, 1'b0);

    // reset pulse mid-stream
    set_ev(0, 8'd1, 32'd64, 32'h60);
    set_ev(1, 8'd1, 32'd64, 32'h61);
    bus.ev_valid = 4'b0011;
    repeat (3) tick();
    rst_n = 1'b0;
    ledger_sel = 2'd2;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_penalty", bus.out_penalty, 32'd0);
    chk("mid_rst_ledger", ledger_val, 32'd0);
    bus.ev_valid = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", bus.out_valid, 1'b0);
    bus.ev_valid = 4'b0110;
    #1;
    chk("post_rst_ptr", bus.ev_ready, 4'b0010);
    tick();
    bus.ev_valid = 4'b0000;
    tick();
    chk("post_rst_res", bus.out_valid, 1'b1);
    chk("post_rst_ch", bus.out_ch, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
